// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel, runtime-programmable clock-enable / square-wave divider.
//   Each channel counts CLK cycles up to its own limit. At the limit it
//   toggles a 50%-duty output and emits a one-cycle tick. A global sync
//   restarts every channel so their outputs come out phase-aligned.
//
// Ports
//   CLK     in   1    system clock, all logic on posedge
//   RST     in   1    synchronous, active-high reset
//   en      in   CH   per-channel count enable (0 = freeze)
//   load    in   CH   per-channel strobe: capture div_in as the new limit
//   div_in  in   W    limit value shared by all load strobes
//   sync    in   1    global restart: counters and outputs to 0
//   t       out  CH   per-channel divided square wave (registered)
//   tick    out  CH   per-channel 1-cycle strobe at each t edge (registered)
// ---------------------------------------------------------------------------

// One divider channel. Holds its own counter, limit, output and strobe.
module clk_div_lane #(
   parameter int W           = 16,
   parameter int DEFAULT_DIV = 25000
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         en,
   input  logic         load,
   input  logic         sync,
   input  logic [W-1:0] div_in,
   output logic         t,
   output logic         tick
);

   localparam logic [W-1:0] LP_DEF = DEFAULT_DIV[W-1:0];
   localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_cnt;
   logic [W-1:0] r_lim;
   logic         r_t;
   logic         r_tick;
   logic         w_wrap;

   // ">=" rather than "==" keeps the counter bounded even if the limit were
   // ever below the count; load always zeroes the count anyway.
   assign w_wrap = (r_cnt >= r_lim);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt  <= '0;
         r_lim  <= LP_DEF;
         r_t    <= 1'b0;
         r_tick <= 1'b0;
      end else if (sync) begin
         // Restart wins over counting, but a coincident load still lands.
         r_cnt  <= '0;
         r_t    <= 1'b0;
         r_tick <= 1'b0;
         if (load) r_lim <= div_in;
      end else if (load) begin
         // New limit restarts the count; t keeps its level.
         r_lim  <= div_in;
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (en) begin
         if (w_wrap) begin
            r_cnt  <= '0;
            r_t    <= ~r_t;
            r_tick <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + LP_ONE;
            r_tick <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign t    = r_t;
   assign tick = r_tick;

endmodule

module clk_div_multi #(
   parameter int CH          = 2,
   parameter int W           = 16,
   parameter int DEFAULT_DIV = 25000
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [CH-1:0] en,
   input  logic [CH-1:0] load,
   input  logic [W-1:0]  div_in,
   input  logic          sync,
   output logic [CH-1:0] t,
   output logic [CH-1:0] tick
);

   // Channels share only the clock, reset, div_in and sync.
   for (genvar g = 0; g < CH; g++) begin : g_lane
      clk_div_lane #(
         .W           (W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_lane (
         .CLK    (CLK),
         .RST    (RST),
         .en     (en[g]),
         .load   (load[g]),
         .sync   (sync),
         .div_in (div_in),
         .t      (t[g]),
         .tick   (tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a 16-bit, 2-channel build with the default limit
// and a 4-bit, 2-channel build (default limit 15) share en/load/sync/RST.
// A countdown model ("enabled cycles left before the next toggle") predicts
// t/tick for all four channels and is compared on every falling edge;
// directed steps also check hand-computed literal values.
module tb_clk_div_multi;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [1:0]  en = 2'b00;
   logic [1:0]  load = 2'b00;
   logic        sync = 1'b0;
   logic [15:0] div_in = '0;
   logic [3:0]  div_b = '0;
   logic [1:0]  t_a, tick_a, t_b, tick_b;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   always #5 CLK = ~CLK;

   clk_div_multi #(.CH(2), .W(16), .DEFAULT_DIV(25000)) u_dut_a (
      .CLK(CLK), .RST(RST), .en(en), .load(load), .div_in(div_in),
      .sync(sync), .t(t_a), .tick(tick_a)
   );

   clk_div_multi #(.CH(2), .W(4), .DEFAULT_DIV(15)) u_dut_b (
      .CLK(CLK), .RST(RST), .en(en), .load(load), .div_in(div_b),
      .sync(sync), .t(t_b), .tick(tick_b)
   );

   // Model: channels 0,1 = build A, 2,3 = build B.
   int m_rem [4];
   int m_lim [4];
   bit m_t   [4];
   bit m_tick[4];

   always @(posedge CLK) begin
      for (int k = 0; k < 4; k++) begin
         int c, d, def;
         c   = k % 2;
         d   = (k < 2) ? int'(div_in) : int'(div_b);
         def = (k < 2) ? 25000 : 15;
         if (RST) begin
            m_lim[k] <= def; m_rem[k] <= def; m_t[k] <= 1'b0; m_tick[k] <= 1'b0;
         end else if (sync) begin
            m_t[k] <= 1'b0; m_tick[k] <= 1'b0;
            if (load[c]) begin m_lim[k] <= d; m_rem[k] <= d; end
            else m_rem[k] <= m_lim[k];
         end else if (load[c]) begin
            m_lim[k] <= d; m_rem[k] <= d; m_tick[k] <= 1'b0;
         end else if (en[c]) begin
            if (m_rem[k] == 0) begin
               m_rem[k] <= m_lim[k]; m_t[k] <= !m_t[k]; m_tick[k] <= 1'b1;
            end else begin
               m_rem[k] <= m_rem[k] - 1; m_tick[k] <= 1'b0;
            end
         end else begin
            m_tick[k] <= 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_on) begin
         for (int k = 0; k < 4; k++) begin
            bit at, ak;
            at = (k < 2) ? t_a[k]    : t_b[k-2];
            ak = (k < 2) ? tick_a[k] : tick_b[k-2];
            checks = checks + 1;
            if (at !== m_t[k] || ak !== m_tick[k]) begin
               errors = errors + 1;
               $display("FAIL model ch%0d @%0t: t=%0b tick=%0b, want t=%0b tick=%0b",
                        k, $time, at, ak, m_t[k], m_tick[k]);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   // Let n rising edges pass, then park on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      // 1: reset, then first toggles
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_on = 1'b1;
      chk("rst_t_a", int'(t_a), 0);
      chk("rst_tick_a", int'(tick_a), 0);
      chk("rst_t_b", int'(t_b), 0);
      RST = 1'b0; en = 2'b11;
      step(15);
      chk("w4_pre_wrap_t", int'(t_b), 0);
      step(1);
      chk("w4_wrap_t", int'(t_b), 3);
      chk("w4_wrap_tick", int'(tick_b), 3);
      step(1);
      chk("w4_tick_drop", int'(tick_b), 0);
      step(25000 - 17);
      chk("a_pre_rise_t", int'(t_a), 0);
      step(1);
      chk("a_rise_t", int'(t_a), 3);
      chk("a_rise_tick", int'(tick_a), 3);
      step(1);
      chk("a_tick_once", int'(tick_a), 0);
      chk("a_t_hold", int'(t_a), 3);

      // 2: ch0 limit 3
      load = 2'b01; div_in = 16'd3; div_b = 4'd3;
      step(1);
      load = 2'b00;
      chk("ld_t_keep", int'(t_a[0]), 1);
      chk("ld_tick0", int'(tick_a[0]), 0);
      step(3);
      chk("div4_pre", int'(t_a[0]), 1);
      step(1);
      chk("div4_fall", int'(t_a[0]), 0);
      chk("div4_tick", int'(tick_a[0]), 1);
      step(4);
      chk("div4_rise", int'(t_a[0]), 1);
      chk("ch1_untouched", int'(t_a[1]), 1);

      // 3: ch1 limit 0, then freeze
      load = 2'b10; div_in = 16'd0; div_b = 4'd0;
      step(1);
      load = 2'b00;
      step(1);
      chk("half_t0", int'(t_a[1]), 0);
      chk("half_tick0", int'(tick_a[1]), 1);
      step(1);
      chk("half_t1", int'(t_a[1]), 1);
      chk("half_tick1", int'(tick_a[1]), 1);
      en = 2'b01;
      step(5);
      chk("frz_t", int'(t_a[1]), 1);
      chk("frz_tick", int'(tick_a[1]), 0);

      // 4: sync+load lim 9, pause at cnt 5
      sync = 1'b1; load = 2'b01; div_in = 16'd9; div_b = 4'd9;
      step(1);
      sync = 1'b0; load = 2'b00;
      chk("sync_t", int'(t_a), 0);
      chk("sync_tick", int'(tick_a), 0);
      step(5);
      en = 2'b00;
      step(7);
      chk("pause_t", int'(t_a[0]), 0);
      en = 2'b01;
      step(4);
      chk("resume_pre", int'(t_a[0]), 0);
      step(1);
      chk("resume_tog", int'(t_a[0]), 1);
      chk("resume_tick", int'(tick_a[0]), 1);

      // 5: lims 3 and 5, sync aligns them
      en = 2'b11; load = 2'b01; div_in = 16'd3; div_b = 4'd3;
      step(1);
      load = 2'b10; div_in = 16'd5; div_b = 4'd5;
      step(1);
      load = 2'b00;
      step(10);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk("al_t", int'(t_a), 0);
      chk("al_tick", int'(tick_a), 0);
      step(3);
      chk("al_p3", int'(t_a), 0);
      step(1);
      chk("al_p4_t", int'(t_a), 1);
      chk("al_p4_tick", int'(tick_a), 1);
      step(1);
      chk("al_p5_t1", int'(t_a[1]), 0);
      step(1);
      chk("al_p6_t", int'(t_a), 3);
      chk("al_p6_tick", int'(tick_a), 2);

      // 6: reset mid-count (ch0 cnt=2, t=1, lim=3)
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      chk("mrst_t", int'(t_a), 0);
      chk("mrst_tick", int'(tick_a), 0);
      step(50);
      chk("mrst_lim_default", int'(t_a), 0);

      // random soak against the model
      repeat (400) begin
         en     = 2'($urandom);
         load   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         sync   = ($urandom_range(0, 31) == 0);
         div_in = 16'($urandom_range(0, 7));
         div_b  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         step(1);
      end

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
